// File: rtl/crack_scheduler.sv
// Key-space scheduler for a pool of ARC4 crack cores: hands out power-of-two
// key chunks to idle cores, latches the first found key and copies its plaintext.
module crack_scheduler #(
  parameter int unsigned NUM_CORES  = 2,
  parameter int unsigned CHUNK_LOG2 = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  output logic                      rdy,
  output logic [23:0]               key,
  output logic                      key_valid,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [23:0]               core_base,
  output logic                      core_abort,
  input  logic [NUM_CORES-1:0]      core_done,
  input  logic [NUM_CORES-1:0]      core_found,
  input  logic [24*NUM_CORES-1:0]   core_key,
  output logic [7:0]                cpy_addr,
  input  logic [8*NUM_CORES-1:0]    cpy_rddata,
  output logic [7:0]                pt_addr,
  output logic [7:0]                pt_wrdata,
  output logic                      pt_wren
);

  localparam int unsigned WW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [24:0] CHUNK = 25'd1 << CHUNK_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_ABORT, S_CPY_RD, S_CPY_WR, S_DONE, S_FAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [23:0]            next_base_q, next_base_d;
  logic                   exhausted_q, exhausted_d;
  logic [NUM_CORES-1:0]   busy_q, busy_d;
  logic [WW-1:0]          win_q, win_d;
  logic [7:0]             k_q, k_d;
  logic [7:0]             len_q, len_d;
  logic [23:0]            key_q, key_d;
  logic [NUM_CORES-1:0]   core_start_q, core_start_d;
  logic [23:0]            core_base_q, core_base_d;

  logic                   start;
  logic [NUM_CORES-1:0]   found_v, idle_v;
  logic                   found_any, idle_any;
  logic [WW-1:0]          found_idx, idle_idx;
  logic [23:0]            win_key;
  logic [7:0]             rd_byte;
  logic                   issue;
  logic [23:0]            base_src;
  logic [24:0]            base_sum;

  // Done pulses from cores we never dispatched to are masked out here.
  always_comb begin
    start     = ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL)) && en;
    found_v   = core_done & core_found & busy_q;
    idle_v    = start ? '1 : ~busy_q;
    found_any = 1'b0;
    found_idx = '0;
    idle_any  = 1'b0;
    idle_idx  = '0;
    win_key   = '0;
    rd_byte   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (found_v[i] && !found_any) begin
        found_any = 1'b1;
        found_idx = WW'(i);
      end
      if (idle_v[i] && !idle_any) begin
        idle_any = 1'b1;
        idle_idx = WW'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (found_idx == WW'(i)) win_key = core_key[24*i +: 24];
      if (win_q == WW'(i))     rd_byte = cpy_rddata[8*i +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    next_base_d  = next_base_q;
    exhausted_d  = exhausted_q;
    busy_d       = busy_q;
    win_d        = win_q;
    k_d          = k_q;
    len_d        = len_q;
    key_d        = key_q;
    core_start_d = '0;
    core_base_d  = core_base_q;
    issue        = 1'b0;
    base_src     = next_base_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (en) begin
          state_d     = S_RUN;
          next_base_d = '0;
          exhausted_d = 1'b0;
          busy_d      = '0;
          k_d         = '0;
          base_src    = '0;
          issue       = 1'b1;
        end
      end
      S_RUN: begin
        busy_d = busy_q & ~core_done;
        if (found_any) begin
          key_d   = win_key;
          win_d   = found_idx;
          state_d = S_ABORT;
        end else if (exhausted_q && (busy_q == '0)) begin
          state_d = S_FAIL;
        end else begin
          issue = !exhausted_q;
        end
      end
      S_ABORT: begin
        busy_d  = '0;
        state_d = S_CPY_RD;
      end
      S_CPY_RD: state_d = S_CPY_WR;
      S_CPY_WR: begin
        // Byte 0 is the length prefix; it bounds the copy on the same cycle it arrives.
        if (k_q == '0) len_d = rd_byte;
        if ((k_q == '0) ? (rd_byte == '0) : (k_q == len_q)) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = S_CPY_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dispatch decision uses last cycle's busy, so a completing core waits a cycle.
    base_sum = {1'b0, base_src} + CHUNK;
    if (issue && idle_any) begin
      core_start_d[idle_idx] = 1'b1;
      core_base_d            = base_src;
      busy_d[idle_idx]       = 1'b1;
      next_base_d            = base_sum[23:0];
      exhausted_d            = base_sum[24];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      next_base_q  <= '0;
      exhausted_q  <= 1'b0;
      busy_q       <= '0;
      win_q        <= '0;
      k_q          <= '0;
      len_q        <= '0;
      key_q        <= '0;
      core_start_q <= '0;
      core_base_q  <= '0;
    end else begin
      state_q      <= state_d;
      next_base_q  <= next_base_d;
      exhausted_q  <= exhausted_d;
      busy_q       <= busy_d;
      win_q        <= win_d;
      k_q          <= k_d;
      len_q        <= len_d;
      key_q        <= key_d;
      core_start_q <= core_start_d;
      core_base_q  <= core_base_d;
    end
  end

  always_comb begin
    rdy        = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
    key_valid  = (state_q == S_DONE);
    key        = key_q;
    core_start = core_start_q;
    core_base  = core_base_q;
    core_abort = (state_q == S_ABORT);
    cpy_addr   = k_q;
    pt_addr    = k_q;
    pt_wrdata  = rd_byte;
    pt_wren    = (state_q == S_CPY_WR);
  end

endmodule
